// File: rtl/nios_system_nios2_cpu_debug_cmd_sched.sv
// Debug command scheduler: queues JTAG take_action strobes as {code, jdo}
// and offers them one at a time to the OCI resource with a per-command timeout.
module nios_system_nios2_cpu_debug_cmd_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_action_break_a,
  input  logic        take_action_break_b,
  input  logic        take_action_break_c,
  input  logic        take_action_tracectrl,
  output logic        cmd_valid,
  output logic [2:0]  cmd_type,
  output logic [37:0] cmd_data,
  input  logic        cmd_ready,
  output logic        busy,
  output logic [2:0]  err_status,
  input  logic        err_clear
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_OFFER = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [40:0]   mem [FIFO_DEPTH];
  logic [40:0]   head;
  logic [15:0]   timer;

  logic [5:0]    strobes;
  logic [2:0]    req_code;
  logic          req_found;
  logic          req_any;
  logic          req_multi;

  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          overflow;
  logic          accept;
  logic          expire;
  logic          nonempty_next;
  logic [2:0]    new_err;

  assign strobes = {take_action_tracectrl, take_action_break_c, take_action_break_b,
                    take_action_break_a, take_action_ocimem_b, take_action_ocimem_a};

  // Lowest code wins when several strobes coincide.
  always_comb begin
    req_code  = '0;
    req_found = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (strobes[i] && !req_found) begin
        req_code  = 3'(i);
        req_found = 1'b1;
      end
    end
  end

  assign req_any   = |strobes;
  assign req_multi = (strobes & (strobes - 6'd1)) != '0;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // A pop in the same cycle frees a slot, so a strobe into a full queue still fits.
  assign pop      = (state == ST_LOAD);
  assign push     = req_any && (!full || pop);
  assign overflow = req_any && full && !pop;

  assign accept        = (state == ST_OFFER) && cmd_ready;
  assign expire        = (state == ST_OFFER) && !cmd_ready && (timer == '0);
  assign nonempty_next = !empty || push;

  assign new_err   = {expire, req_multi, overflow};
  assign cmd_valid = (state == ST_OFFER);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (nonempty_next) state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_OFFER;
      ST_OFFER: if (accept || expire) state_next = nonempty_next ? ST_LOAD : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr[AW-1:0]] <= {req_code, jdo};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      timer      <= '0;
      cmd_type   <= '0;
      cmd_data   <= '0;
      busy       <= 1'b0;
      err_status <= '0;
    end else begin
      state <= state_next;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        cmd_type <= head[40:38];
        cmd_data <= head[37:0];
        timer    <= 16'(TIMEOUT);
      end else if ((state == ST_OFFER) && !accept && !expire) begin
        timer <= timer - 16'd1;
      end
      busy       <= (state != ST_IDLE) || !empty;
      err_status <= (err_clear ? 3'b000 : err_status) | new_err;
    end
  end

endmodule

// File: tb/tb_nios_system_nios2_cpu_debug_cmd_sched.sv
// Bench for the debug command scheduler: directed vector table, multi-cycle
// corner sequences and a randomized run against a queue-based reference model.
module tb_nios_system_nios2_cpu_debug_cmd_sched;

  localparam int DEPTH = 4;
  localparam int TO    = 3;

  logic        clk;
  logic        rst;
  logic [5:0]  stb;
  logic [37:0] jdo;
  logic        rdy;
  logic        clr;

  logic        cmd_valid;
  logic [2:0]  cmd_type;
  logic [37:0] cmd_data;
  logic        busy;
  logic [2:0]  err_status;

  int n_cmp = 0;
  int n_err = 0;

  nios_system_nios2_cpu_debug_cmd_sched #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk                   (clk),
    .reset                 (rst),
    .jdo                   (jdo),
    .take_action_ocimem_a  (stb[0]),
    .take_action_ocimem_b  (stb[1]),
    .take_action_break_a   (stb[2]),
    .take_action_break_b   (stb[3]),
    .take_action_break_c   (stb[4]),
    .take_action_tracectrl (stb[5]),
    .cmd_valid             (cmd_valid),
    .cmd_type              (cmd_type),
    .cmd_data              (cmd_data),
    .cmd_ready             (rdy),
    .busy                  (busy),
    .err_status            (err_status),
    .err_clear             (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log of commands the DUT actually handed over.
  logic [40:0] dut_log [$];
  always @(posedge clk) begin
    if (!rst && cmd_valid && rdy) dut_log.push_back({cmd_type, cmd_data});
  end

  // Reference model: a plain queue plus a slot that is either loading or being offered.
  logic [40:0] mq [$];
  bit          m_loading;
  bit          m_offering;
  int          m_age;
  logic [2:0]  m_type;
  logic [37:0] m_data;
  bit          m_busy;
  logic [2:0]  m_err;

  task automatic model_step();
    logic [2:0]  new_err;
    bit          was_loading, was_offering, full_before, done, busy_next;
    int          code, nset;
    logic [40:0] hd;
    if (rst) begin
      mq.delete();
      m_loading = 0; m_offering = 0; m_age = 0;
      m_type = '0; m_data = '0; m_busy = 0; m_err = '0;
      return;
    end
    new_err = '0; done = 0; code = -1; nset = 0;
    was_loading  = m_loading;
    was_offering = m_offering;
    busy_next    = was_loading || was_offering || (mq.size() != 0);
    full_before  = (mq.size() == DEPTH);
    if (was_loading) begin
      hd = mq.pop_front();
      m_type = hd[40:38];
      m_data = hd[37:0];
    end
    for (int i = 0; i < 6; i++) begin
      if (stb[i]) begin
        nset++;
        if (code < 0) code = i;
      end
    end
    if (nset > 1) new_err[1] = 1'b1;
    if (nset > 0) begin
      if (full_before && !was_loading) new_err[0] = 1'b1;
      else mq.push_back({3'(code), jdo});
    end
    if (was_offering) begin
      if (rdy) done = 1;
      else if (m_age == TO) begin
        new_err[2] = 1'b1;
        done = 1;
      end else m_age++;
    end
    if (was_loading) begin
      m_loading = 0; m_offering = 1; m_age = 0;
    end else if (done || !was_offering) begin
      m_offering = 0;
      m_loading  = (mq.size() != 0);
    end
    m_err  = (clr ? 3'b000 : m_err) | new_err;
    m_busy = busy_next;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input string name);
    @(posedge clk);
    model_step();
    #1;
    chk(name, 64'({cmd_valid, cmd_type, cmd_data, busy, err_status}),
              64'({m_offering, m_type, m_data, m_busy, m_err}));
  endtask

  task automatic reset_dut();
    rst = 1'b1; stb = '0; clr = 1'b0; rdy = 1'b0; jdo = '0;
    tick("reset");
    rst = 1'b0;
    dut_log.delete();
  endtask

  typedef struct {
    logic        rst;
    logic [5:0]  stb;
    logic [37:0] jdo;
    logic        rdy;
    logic        clr;
    logic        v;
    logic [2:0]  ty;
    logic [37:0] d;
    logic        b;
    logic [2:0]  e;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [11:0] pat;
    logic [2:0]  ty_a, ty_b;
    int          base;

    rst = 1'b1; stb = '0; jdo = '0; rdy = 1'b0; clr = 1'b0;

    //              rst stb    jdo              rdy clr  v  ty    d                b  e
    tbl[0]  = '{1'b1, 6'h00, 38'h0,           1'b1, 1'b0, 1'b0, 3'd0, 38'h0,           1'b0, 3'b000};
    tbl[1]  = '{1'b0, 6'h08, 38'h2A_1234_5678, 1'b1, 1'b0, 1'b0, 3'd0, 38'h0,           1'b0, 3'b000};
    tbl[2]  = '{1'b0, 6'h00, 38'h0,           1'b1, 1'b0, 1'b1, 3'd3, 38'h2A_1234_5678, 1'b1, 3'b000};
    tbl[3]  = '{1'b0, 6'h00, 38'h0,           1'b1, 1'b0, 1'b0, 3'd3, 38'h2A_1234_5678, 1'b1, 3'b000};
    tbl[4]  = '{1'b0, 6'h00, 38'h0,           1'b1, 1'b0, 1'b0, 3'd3, 38'h2A_1234_5678, 1'b0, 3'b000};
    tbl[5]  = '{1'b0, 6'h06, 38'h11,          1'b1, 1'b0, 1'b0, 3'd3, 38'h2A_1234_5678, 1'b0, 3'b010};
    tbl[6]  = '{1'b0, 6'h00, 38'h0,           1'b1, 1'b0, 1'b1, 3'd1, 38'h11,          1'b1, 3'b010};
    tbl[7]  = '{1'b0, 6'h00, 38'h0,           1'b1, 1'b0, 1'b0, 3'd1, 38'h11,          1'b1, 3'b010};
    tbl[8]  = '{1'b0, 6'h00, 38'h0,           1'b1, 1'b1, 1'b0, 3'd1, 38'h11,          1'b0, 3'b000};
    tbl[9]  = '{1'b0, 6'h21, 38'h22,          1'b1, 1'b1, 1'b0, 3'd1, 38'h11,          1'b0, 3'b010};
    tbl[10] = '{1'b0, 6'h00, 38'h0,           1'b1, 1'b0, 1'b1, 3'd0, 38'h22,          1'b1, 3'b010};
    tbl[11] = '{1'b0, 6'h00, 38'h0,           1'b1, 1'b0, 1'b0, 3'd0, 38'h22,          1'b1, 3'b010};
    tbl[12] = '{1'b0, 6'h00, 38'h0,           1'b1, 1'b1, 1'b0, 3'd0, 38'h22,          1'b0, 3'b000};

    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst; stb = tbl[i].stb; jdo = tbl[i].jdo; rdy = tbl[i].rdy; clr = tbl[i].clr;
      tick($sformatf("vec%0d_model", i));
      chk($sformatf("vec%0d", i), 64'({cmd_valid, cmd_type, cmd_data, busy, err_status}),
          64'({tbl[i].v, tbl[i].ty, tbl[i].d, tbl[i].b, tbl[i].e}));
    end

    // Overflow with the timeout race folded in: ready rises on the final offer cycle.
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      stb = 6'h01; jdo = 38'(100 + i); rdy = (i == 5);
      tick("ovf_fill");
    end
    stb = '0;
    chk("ovf_err", 64'(err_status), 64'(3'b001));
    chk("race_accept", 64'(dut_log.size()), 64'(1));
    rdy = 1'b1;
    for (int i = 0; i < 12; i++) tick("ovf_drain");
    chk("ovf_count", 64'(dut_log.size()), 64'(5));
    for (int k = 0; k < 5 && k < dut_log.size(); k++)
      chk($sformatf("ovf_order%0d", k), 64'(dut_log[k]), 64'({3'd0, 38'(100 + k)}));
    chk("ovf_err_final", 64'(err_status), 64'(3'b001));

    // Timeout: two commands, neither ever accepted.
    reset_dut();
    pat = '0; ty_a = '0; ty_b = '0;
    stb = 6'h20; jdo = 38'd7;
    tick("to_strobe");
    for (int t = 1; t <= 12; t++) begin
      stb = (t == 1) ? 6'h02 : 6'h00; jdo = 38'd8;
      tick("to_run");
      pat = {pat[10:0], cmd_valid};
      if (t == 1) ty_a = cmd_type;
      if (t == 6) ty_b = cmd_type;
    end
    chk("to_valid_pattern", 64'(pat), 64'(12'b1111_0111_1000));
    chk("to_type_first", 64'(ty_a), 64'(3'd5));
    chk("to_type_second", 64'(ty_b), 64'(3'd1));
    chk("to_err", 64'(err_status), 64'(3'b100));
    chk("to_busy_end", 64'(busy), 64'(1'b0));
    chk("to_no_accept", 64'(dut_log.size()), 64'(0));

    // Reset in the middle of an offer with three more queued.
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      stb = 6'(1 << i); jdo = 38'(200 + i);
      tick("mid_fill");
    end
    chk("mid_offering", 64'(cmd_valid), 64'(1'b1));
    rst = 1'b1; stb = 6'h10; jdo = 38'd999;
    tick("mid_reset");
    chk("mid_rst_valid", 64'(cmd_valid), 64'(1'b0));
    chk("mid_rst_busy", 64'(busy), 64'(1'b0));
    rst = 1'b0; stb = '0; rdy = 1'b1;
    base = dut_log.size();
    for (int i = 0; i < 10; i++) tick("mid_quiet");
    chk("mid_no_deliver", 64'(dut_log.size()), 64'(base));
    stb = 6'h10; jdo = 38'd300;
    tick("mid_new");
    stb = '0;
    for (int i = 0; i < 6; i++) tick("mid_new_drain");
    chk("mid_new_count", 64'(dut_log.size()), 64'(base + 1));
    if (dut_log.size() > base)
      chk("mid_new_cmd", 64'(dut_log[base]), 64'({3'd4, 38'd300}));

    // Randomized traffic against the model.
    reset_dut();
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      stb = '0;
      if (r >= 5) stb[$urandom_range(0, 5)] = 1'b1;
      if (r == 9) stb[$urandom_range(0, 5)] = 1'b1;
      jdo = {6'($urandom_range(0, 63)), 32'($urandom())};
      rdy = ($urandom_range(0, 9) < 3);
      clr = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
